// File: rtl/tap_window_shift.sv
// Sliding window of the last TAPS samples: tap 0 is the live input, taps 1..TAPS-1 are
// the accepted-sample history, cleared by reset or flush at line/frame boundaries.
module tap_window_shift #(
  parameter int DATA_W = 8,
  parameter int TAPS   = 3,
  localparam int FILL_W = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_valid,
  input  logic                     flush,
  output logic [DATA_W*TAPS-1:0]   taps,
  output logic                     win_valid,
  output logic [FILL_W-1:0]        fill
);

  localparam int HIST_W = DATA_W * (TAPS - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAPS - 1);

  // hist slice j holds tap j+1
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (flush) begin
      hist_d = '0;
      fill_d = '0;
    end else if (din_valid) begin
      hist_d[0 +: DATA_W] = din;
      for (int k = 1; k < TAPS - 1; k++) begin
        hist_d[k*DATA_W +: DATA_W] = hist_q[(k-1)*DATA_W +: DATA_W];
      end
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign taps      = {hist_q, din};
  assign fill      = fill_q;
  assign win_valid = din_valid & (fill_q == FILL_MAX) & ~flush & ~rst;

endmodule

// File: tb/tb_tap_window_shift.sv
// Bench for tap_window_shift: a queue-based window model checked every negedge, plus
// directed vectors with hand-computed expectations on an 8x3 and a 12x5 instance.
module tb_tap_window_shift;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  din_a = '0;
  logic        din_valid_a = 1'b0, flush_a = 1'b0;
  logic [23:0] taps_a;
  logic        win_valid_a;
  logic [1:0]  fill_a;

  logic [11:0] din_b = '0;
  logic        din_valid_b = 1'b0, flush_b = 1'b0;
  logic [59:0] taps_b;
  logic        win_valid_b;
  logic [2:0]  fill_b;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  tap_window_shift #(.DATA_W(8), .TAPS(3)) u_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(din_valid_a), .flush(flush_a),
    .taps(taps_a), .win_valid(win_valid_a), .fill(fill_a)
  );

  tap_window_shift #(.DATA_W(12), .TAPS(5)) u_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(din_valid_b), .flush(flush_b),
    .taps(taps_b), .win_valid(win_valid_b), .fill(fill_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: newest-first list of accepted samples since the last reset/flush
  logic [7:0]  hist_a[$];
  logic [11:0] hist_b[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_a.delete();
      hist_b.delete();
    end else begin
      if (flush_a) hist_a.delete();
      else if (din_valid_a) begin
        hist_a.push_front(din_a);
        if (hist_a.size() > 2) void'(hist_a.pop_back());
      end
      if (flush_b) hist_b.delete();
      else if (din_valid_b) begin
        hist_b.push_front(din_b);
        if (hist_b.size() > 4) void'(hist_b.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    logic [23:0] exp_a;
    logic [59:0] exp_b;
    exp_a = {16'h0, din_a};
    for (int k = 1; k < 3; k++)
      if (k - 1 < hist_a.size()) exp_a[k*8 +: 8] = hist_a[k-1];
    exp_b = {48'h0, din_b};
    for (int k = 1; k < 5; k++)
      if (k - 1 < hist_b.size()) exp_b[k*12 +: 12] = hist_b[k-1];
    chk("model_taps_a", 64'(taps_a), 64'(exp_a));
    chk("model_fill_a", 64'(fill_a), 64'(hist_a.size()));
    chk("model_win_a", 64'(win_valid_a),
        64'(din_valid_a && hist_a.size() == 2 && !flush_a && !rst));
    chk("model_taps_b", 64'(taps_b), 64'(exp_b));
    chk("model_fill_b", 64'(fill_b), 64'(hist_b.size()));
    chk("model_win_b", 64'(win_valid_b),
        64'(din_valid_b && hist_b.size() == 4 && !flush_b && !rst));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic [7:0] d, input logic v, input logic f);
    din_a = d; din_valid_a = v; flush_a = f;
    #1;
  endtask

  initial begin
    repeat (2) step();
    // reset state
    chk("rst_fill", 64'(fill_a), 64'd0);
    chk("rst_taps", 64'(taps_a[23:8]), 64'd0);
    rst = 1'b0;

    // consecutive fill
    drv_a(8'h11, 1, 0);
    chk("fill0_win", 64'(win_valid_a), 64'd0);
    chk("fill0_fill", 64'(fill_a), 64'd0);
    step();
    drv_a(8'h22, 1, 0);
    chk("fill1_win", 64'(win_valid_a), 64'd0);
    chk("fill1_fill", 64'(fill_a), 64'd1);
    step();
    drv_a(8'h33, 1, 0);
    chk("fill2_win", 64'(win_valid_a), 64'd1);
    chk("fill2_taps", 64'(taps_a), 64'h112233);
    chk("fill2_fill", 64'(fill_a), 64'd2);
    step();

    // gap with invalid samples holds history
    drv_a(8'h00, 0, 1); step();
    drv_a(8'h11, 1, 0); step();
    drv_a(8'h22, 1, 0); step();
    for (int i = 0; i < 4; i++) begin
      drv_a(8'hFF, 0, 0);
      chk("gap_taps", 64'(taps_a), 64'h1122FF);
      chk("gap_win", 64'(win_valid_a), 64'd0);
      step();
    end
    drv_a(8'h33, 1, 0);
    chk("gap_end_win", 64'(win_valid_a), 64'd1);
    chk("gap_end_taps", 64'(taps_a), 64'h112233);
    step();

    // flush beats din_valid
    drv_a(8'h44, 1, 1);
    chk("flush_win", 64'(win_valid_a), 64'd0);
    step();
    drv_a(8'h55, 1, 0);
    chk("post_flush_fill", 64'(fill_a), 64'd0);
    chk("post_flush_taps", 64'(taps_a), 64'h000055);
    chk("post_flush_win1", 64'(win_valid_a), 64'd0);
    step();
    drv_a(8'h66, 1, 0);
    chk("post_flush_win2", 64'(win_valid_a), 64'd0);
    chk("post_flush_taps2", 64'(taps_a), 64'h005566);
    step();
    drv_a(8'h77, 1, 0);
    chk("post_flush_win3", 64'(win_valid_a), 64'd1);
    chk("post_flush_taps3", 64'(taps_a), 64'h556677);
    step();

    // async reset mid-stream, between edges
    drv_a(8'h88, 1, 0);
    chk("pre_rst_fill", 64'(fill_a), 64'd2);
    rst = 1'b1;
    #1;
    chk("async_rst_fill", 64'(fill_a), 64'd0);
    chk("async_rst_hist", 64'(taps_a[23:8]), 64'd0);
    chk("async_rst_tap0", 64'(taps_a[7:0]), 64'h88);
    chk("async_rst_win", 64'(win_valid_a), 64'd0);
    step();
    rst = 1'b0;
    drv_a(8'h00, 0, 0);
    step();

    // saturation over a long run
    for (int i = 1; i <= 10; i++) begin
      drv_a(8'(i), 1, 0);
      chk("sat_win", 64'(win_valid_a), 64'(i >= 3));
      chk("sat_fill", 64'(fill_a), 64'(i >= 3 ? 2 : i - 1));
      chk("sat_tap2", 64'(taps_a[23:16]), 64'(i >= 3 ? i - 2 : 0));
      step();
    end
    drv_a(8'h00, 0, 0);
    step();

    // wide instance
    for (int i = 0; i < 6; i++) begin
      din_b = 12'(12'h100 + i); din_valid_b = 1'b1;
      #1;
      chk("w_win", 64'(win_valid_b), 64'(i >= 4));
      chk("w_fill", 64'(fill_b), 64'(i >= 4 ? 4 : i));
      if (i == 5) chk("w_tap4", 64'(taps_b[59:48]), 64'h101);
      step();
    end
    din_valid_b = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tap_window_shift.md
TAP_WINDOW_SHIFT -- requirements
Module: tap_window_shift

Interface
REQ-001 Parameter DATA_W, default 8, sets the pixel/sample width in bits (legal range 1..32).
REQ-002 Parameter TAPS, default 3, sets the number of window taps (legal range 2..16).
REQ-003 Derived FILL_W = clog2(TAPS), which is the width of the fill counter.
REQ-004 Port clk, input, 1 bit, is the single clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1 bit, is the reset: asynchronous, active-high.
REQ-006 Port din, input, DATA_W bits, carries the incoming sample.
REQ-007 Port din_valid, input, 1 bit; when high, din is accepted this cycle.
REQ-008 Port flush, input, 1 bit, is a synchronous clear of the window history (line/frame boundary).
REQ-009 Port taps, output, DATA_W*TAPS bits; slice [k*DATA_W +: DATA_W] is tap k, and tap 0 is the newest.
REQ-010 Port win_valid, output, 1 bit, is high when all TAPS taps hold valid samples of the current segment.
REQ-011 Port fill, output, FILL_W bits, holds the count of history samples held (0..TAPS-1).

Function
REQ-012 Tap 0 shall be combinational: tap0 = din, with zero latency regardless of din_valid.
REQ-013 Taps 1..TAPS-1 shall be registers; tap k is sample din delayed by k accepted samples.
REQ-014 On a clk edge with din_valid=1 and flush=0: tap1 <= din, and tap k <= tap k-1 for k=2..TAPS-1.
REQ-015 On a clk edge with din_valid=0 and flush=0: all tap registers and fill shall hold.
REQ-016 fill shall increment by 1 per accepted sample and saturate at TAPS-1 (no wrap).
REQ-017 win_valid = din_valid AND (fill == TAPS-1) AND NOT flush; this is combinational and unregistered.
REQ-018 On a clk edge with flush=1: tap registers 1..TAPS-1 <= 0 and fill <= 0.
REQ-019 flush shall have priority over din_valid; a sample presented in the flush cycle is discarded and not shifted in.
REQ-020 After a flush, win_valid shall remain 0 until TAPS-1 further samples have been accepted, then assert on the next valid sample.
REQ-021 No tap register shall ever be driven to X or Z; every reset or flush value is 0.
REQ-022 Behaviour shall be identical for every legal DATA_W/TAPS combination, with no special case for TAPS=2.

Reset
REQ-023 While rst=1, the tap registers 1..TAPS-1 and fill shall be 0 immediately, without waiting for a clk edge.
REQ-024 While rst=1, win_valid shall be 0 and tap 0 shall still follow din.
REQ-025 Deassertion of rst shall take effect at the next clk edge; the first accepted sample after reset loads tap 1.
REQ-026 Reset mid-stream shall discard all history; the window restarts empty, as after a flush.

Verification (DATA_W=8, TAPS=3 unless stated)
REQ-027 Reset, then din 0x11,0x22,0x33 with din_valid=1 on consecutive cycles -> win_valid 0,0,1; in the third cycle tap0=0x33, tap1=0x22, tap2=0x11, and fill reads 0,1,2.
REQ-028 Valid samples 0x11,0x22, then 4 cycles of din_valid=0 with din=0xFF, then 0x33 valid -> taps hold 0x22/0x11 through the gap; win_valid=0 in gap cycles and 1 with 0x33.
REQ-029 Full window, then flush=1 with din_valid=1 and din=0x44 -> next cycle fill=0, tap1=tap2=0x00, 0x44 absent; win_valid=0 during the flush cycle and on the next 2 valid samples.
REQ-030 Stream running with fill=2, then pulse rst between clk edges -> tap1, tap2 and fill read 0 before the next edge; win_valid=0.
REQ-031 Send 10 consecutive valid samples 0x01..0x0A -> fill saturates at 2 from sample 3 onward; win_valid=1 on samples 3..10; tap2 always equals the sample from 2 accepted samples earlier.
REQ-032 With DATA_W=12 and TAPS=5, 6 valid samples 0x100..0x105 -> win_valid first high on 0x104; on 0x105, tap4=0x101; fill width is 3 bits and saturates at 4.
